instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 6'd0, meaning the word address fetched first after reset.
REQ-002 The module SHALL have parameter HALT_INSTR, default 32'h00000073 (ECALL), meaning the instruction word that stops fetching.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port imem_addr  output  6  word address to instruction memory; equals the internal PC.
REQ-006 Port imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 Port redirect_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-008 Port redirect_pc  input  6  redirect target word address.
REQ-009 Port if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-010 Port if_ready  input  1  downstream decode accepts when if_valid && if_ready.
REQ-011 Port if_instr  output  32  registered fetched instruction.
REQ-012 Port if_pc  output  6  word address of if_instr.
REQ-013 Port halted  output  1  high while in state HALT.

Function
REQ-014 The FSM SHALL have two states: RUN and HALT.
REQ-015 "Load" SHALL occur in RUN when the output register is empty or being accepted (!if_valid || if_ready) and redirect_valid is low: if_instr<=imem_instr, if_pc<=PC, if_valid<=1, PC<=PC+1.
REQ-016 PC increment SHALL wrap modulo 64 (63 -> 0), with no flag.
REQ-017 Load latency SHALL be one cycle: the word at imem_addr in cycle N appears on if_instr in cycle N+1.
REQ-018 When if_valid && !if_ready, if_instr, if_pc, if_valid and PC SHALL hold unchanged.
REQ-019 With if_valid && !if_ready, the FSM SHALL start no new load.
REQ-020 With if_valid && if_ready and no load (HALT), if_valid SHALL clear next cycle.
REQ-021 redirect_valid SHALL take priority over load, stall and HALT in any state: PC<=redirect_pc, if_valid<=0 (flush, even if stalled), state<=RUN.
REQ-022 The first fetch after redirect SHALL load redirect_pc's word on the following eligible cycle.
REQ-023 When a load captures imem_instr==HALT_INSTR, state SHALL go RUN->HALT; that instruction is still presented and held until accepted.
REQ-024 In HALT, no loads SHALL occur and PC SHALL hold at halt address+1.
REQ-025 HALT SHALL be exited only by redirect_valid or reset.
REQ-026 halted SHALL be 1 exactly when state==HALT.

Reset
REQ-027 On rst_n low, regardless of clock: state=RUN, PC=RESET_PC, if_valid=0, if_instr=32'h0, if_pc=6'h0, halted=0.
REQ-028 Reset SHALL abort a stalled output or HALT immediately, discarding held data.
REQ-029 The first load SHALL occur on the first rising edge with rst_n high.

Structure
REQ-030 The shared package SHALL hold IMEM_ADDR_W=6, INSTR_W=32, the ECALL encoding 32'h00000073 and the fetch-state enum {RUN, HALT}.
REQ-031 The block SHALL be a single module with no sub-modules; instruction memory SHALL be instantiated only by the bench/top.

Verification
REQ-032 Reset, memory words 0..3 = 11111111, 22222222, 33333333, 44444444, if_ready=1 -> if_pc 0,1,2,3 on consecutive cycles, first if_valid one cycle after reset release.
REQ-033 if_ready low for 3 cycles while showing pc 2 -> if_instr=33333333 and imem_addr=3 held for 3 cycles, no skipped or duplicated pc after release.
REQ-034 redirect_valid with redirect_pc=40 while stalled at pc 5 -> next cycle if_valid=0, imem_addr=40, then if_pc=40 one cycle later.
REQ-035 Word 7 = 00000073 -> if_pc=7 presented, halted=1, no further if_valid after acceptance, imem_addr stays 8; redirect_pc=0 then resumes at pc 0.
REQ-036 Run from pc 62 -> if_pc sequence 62, 63, 0, 1.
REQ-037 rst_n low mid-stall at pc 10 -> if_valid=0 immediately (asynchronous), then restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, the ECALL
// encoding and the fetch-state enum.
package instr_fetch_unit_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int INSTR_W     = 32;

  localparam logic [INSTR_W-1:0] ECALL_INSTR = 32'h00000073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: walks the PC through a combinational instruction
// memory, presents one registered instruction at a time and stops on HALT_INSTR.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [IMEM_ADDR_W-1:0] RESET_PC   = 6'd0,
  parameter logic [INSTR_W-1:0]     HALT_INSTR = ECALL_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0]     imem_instr,
  input  logic                   redirect_valid,
  input  logic [IMEM_ADDR_W-1:0] redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INSTR_W-1:0]     if_instr,
  output logic [IMEM_ADDR_W-1:0] if_pc,
  output logic                   halted
);

  fetch_state_t           state;
  fetch_state_t           state_next;
  logic [IMEM_ADDR_W-1:0] pc;
  logic                   load;

  // A redirect overrides everything; otherwise load whenever the output slot frees up.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    if (redirect_valid) begin
      state_next = RUN;
    end else if ((state == RUN) && (!if_valid || if_ready)) begin
      load = 1'b1;
      if (imem_instr == HALT_INSTR) begin
        state_next = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (load) begin
      pc <= pc + IMEM_ADDR_W'(1);
    end
  end

  // The flush drops only if_valid; stale if_instr/if_pc are harmless once invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_instr <= imem_instr;
      if_pc    <= pc;
    end else if (if_ready) begin
      if_valid <= 1'b0;
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == HALT);

endmodule
